matmul_sequencer: RTL and testbench

Sequencer that executes the accelerator's matrix operation once the host has written the control registers (operation, w_A, h_A, w_B, h_B) and issued the go write. It walks matrices A and B in the shared matrix memory, multiply-accumulates each output element and writes C back to the same memory. It shares that memory with the Wishbone slave path through a request/grant port, so host accesses may stall it at any cycle.

---
 rtl/matmul_sequencer.sv | 165 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks A and B in the shared matrix memory, multiply-
// accumulates each C element and writes it back over a request/grant port.
module matmul_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int MAX_DIM = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [7:0]        w_a,
    input  logic [7:0]        h_a,
    input  logic [7:0]        w_b,
    input  logic [7:0]        h_b,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_A, RD_B, ACC, WR_C, FIN
    } state_t;

    localparam logic [7:0] MAX_D = 8'(MAX_DIM);

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [7:0]        wa_q, ha_q, wb_q, hb_q;
    logic [ADDR_W-1:0] ba_q, bb_q, bc_q;
    logic [7:0]        i_q, j_q, k_q;
    logic [DATA_W-1:0] acc_q, opa_q;
    logic              a_gnt_q, err_q;
    logic              illegal, k_last, last_elem;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;

    assign illegal = (op_q != 3'd1) || (wa_q != hb_q)
                  || (wa_q == 8'd0) || (ha_q == 8'd0)
                  || (wb_q == 8'd0) || (hb_q == 8'd0)
                  || (wa_q > MAX_D) || (ha_q > MAX_D)
                  || (wb_q > MAX_D) || (hb_q > MAX_D);

    assign k_last    = (k_q == wa_q - 8'd1);
    assign last_elem = (i_q == ha_q - 8'd1) && (j_q == wb_q - 8'd1);

    assign addr_a = ba_q + ADDR_W'(i_q) * ADDR_W'(wa_q) + ADDR_W'(k_q);
    assign addr_b = bb_q + ADDR_W'(k_q) * ADDR_W'(wb_q) + ADDR_W'(j_q);
    assign addr_c = bc_q + ADDR_W'(i_q) * ADDR_W'(wb_q) + ADDR_W'(j_q);

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign err  = err_q;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and memory port drive; port fields only depend on
    // registered state so they hold steady across a stalled request
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE:  if (start) state_d = CHECK;
            CHECK: state_d = illegal ? FIN : RD_A;
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = addr_a;
                if (mem_gnt) state_d = RD_B;
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = addr_b;
                if (mem_gnt) state_d = ACC;
            end
            ACC:   state_d = k_last ? WR_C : RD_A;
            WR_C: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_c;
                mem_wdata = acc_q;
                if (mem_gnt) state_d = last_elem ? FIN : RD_A;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Parameter latch, loop counters, operand capture and accumulator
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            op_q    <= '0;
            wa_q    <= '0;
            ha_q    <= '0;
            wb_q    <= '0;
            hb_q    <= '0;
            ba_q    <= '0;
            bb_q    <= '0;
            bc_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            a_gnt_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_gnt_q <= (state_q == RD_A) && mem_gnt;
            case (state_q)
                IDLE: if (start) begin
                    op_q  <= op;
                    wa_q  <= w_a;
                    ha_q  <= h_a;
                    wb_q  <= w_b;
                    hb_q  <= h_b;
                    ba_q  <= base_a;
                    bb_q  <= base_b;
                    bc_q  <= base_c;
                    err_q <= 1'b0;
                end
                CHECK: begin
                    if (illegal) begin
                        err_q <= 1'b1;
                    end else begin
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                RD_B: if (a_gnt_q) opa_q <= mem_rdata;
                ACC: begin
                    acc_q <= acc_q + opa_q * mem_rdata;
                    if (!k_last) k_q <= k_q + 8'd1;
                end
                WR_C: if (mem_gnt) begin
                    k_q   <= '0;
                    acc_q <= '0;
                    if (j_q == wb_q - 8'd1) begin
                        j_q <= '0;
                        i_q <= i_q + 8'd1;
                    end else begin
                        j_q <= j_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized and directed runs against a memory
// model and a plain-arithmetic matrix product reference.
module tb_matmul_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  w_a, h_a, w_b, h_b;
    logic [9:0]  base_a, base_b, base_c;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic        busy, done, err;

    logic [31:0] mem [0:1023];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    bit          gnt_rand = 1'b0;
    int          req_cnt = 0;
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [9:0]  p_addr = '0;
    logic        p_we = 1'b0;
    logic [31:0] p_wdata = '0;

    logic [31:0] am [0:255];
    logic [31:0] bm [0:255];

    int checks = 0;
    int failures = 0;

    matmul_sequencer dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .op        (op),
        .w_a       (w_a),
        .h_a       (h_a),
        .w_b       (w_b),
        .h_b       (h_b),
        .base_a    (base_a),
        .base_b    (base_b),
        .base_c    (base_c),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Grant generator: always granted, or a coin flip per cycle
    always @(negedge wb_clk_i)
        mem_gnt <= gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    // Memory model plus a monitor that port fields hold while stalled
    always @(posedge wb_clk_i) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_req && mem_gnt && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_req && mem_gnt && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= $urandom;
        if (mem_req) req_cnt++;
        if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we
                     || mem_wdata != p_wdata))
            stab_err++;
        pend    <= mem_req && !mem_gnt;
        p_addr  <= mem_addr;
        p_we    <= mem_we;
        p_wdata <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = 10'(addr);
        ld_data = data;
        @(negedge wb_clk_i);
        ld_en   = 1'b0;
    endtask

    task automatic load(input int ha, input int wa, input int wb,
                        input int ba, input int bb, input int bc);
        for (int x = 0; x < ha * wa; x++) poke(ba + x, am[x]);
        for (int x = 0; x < wa * wb; x++) poke(bb + x, bm[x]);
        for (int x = 0; x < ha * wb; x++) poke(bc + x, $urandom);
    endtask

    task automatic check_c(input string tag, input int ha, input int wa,
                           input int wb, input int bc);
        logic [31:0] s;
        for (int i = 0; i < ha; i++)
            for (int j = 0; j < wb; j++) begin
                s = '0;
                for (int k = 0; k < wa; k++)
                    s = s + am[i * wa + k] * bm[k * wb + j];
                chk(tag, mem[bc + i * wb + j], s);
            end
    endtask

    task automatic set_params(input logic [2:0] o, input int wa, input int ha,
                              input int wb, input int hb, input int ba,
                              input int bb, input int bc);
        op     = o;
        w_a    = 8'(wa);
        h_a    = 8'(ha);
        w_b    = 8'(wb);
        h_b    = 8'(hb);
        base_a = 10'(ba);
        base_b = 10'(bb);
        base_c = 10'(bc);
    endtask

    // Start a run, wait for done; exp_lat <= 0 skips the latency check and
    // intf_cyc > 0 fires a stray illegal start while the run is busy
    task automatic run(input string tag, input bit exp_err,
                       input int exp_lat, input int intf_cyc);
        int cyc;
        int rq0;
        rq0   = req_cnt;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 14000) begin
            start = (cyc == intf_cyc);
            if (cyc == intf_cyc) op = 3'd2;
            @(negedge wb_clk_i);
            start = 1'b0;
            cyc++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_lat > 0) chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_err"}, 32'(err), 32'(exp_err));
            if (exp_err) chk({tag, "_noreq"}, 32'(req_cnt), 32'(rq0));
            start = 1'b1;
            @(negedge wb_clk_i);
            start = 1'b0;
            chk({tag, "_finstart"}, 32'(busy), 32'd0);
            chk({tag, "_donepulse"}, 32'(done), 32'd0);
        end
    endtask

    task automatic setup_2x2();
        am[0] = -32'sd3;  am[1] = -32'sd15;
        am[2] = -32'sd6;  am[3] = 32'sd7;
        bm[0] = 32'sd9;   bm[1] = -32'sd15;
        bm[2] = -32'sd2;  bm[3] = -32'sd5;
        load(2, 2, 2, 6, 10, 14);
        set_params(3'd1, 2, 2, 2, 2, 6, 10, 14);
    endtask

    initial begin
        int wa, ha, wb, rq;
        wb_rst_i = 1'b1;
        start    = 1'b0;
        set_params(3'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge wb_clk_i);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        setup_2x2();
        run("mm2", 1'b0, 30, 0);
        check_c("mm2_c", 2, 2, 2, 14);
        chk("mm2_c00", mem[14], 32'd3);
        chk("mm2_c10", mem[16], -32'sd68);

        gnt_rand = 1'b1;
        setup_2x2();
        run("mm2g", 1'b0, 0, 0);
        check_c("mm2g_c", 2, 2, 2, 14);
        gnt_rand = 1'b0;

        set_params(3'd1, 2, 2, 2, 3, 6, 10, 14);
        run("bad_dim", 1'b1, 2, 0);
        set_params(3'd2, 2, 2, 2, 2, 6, 10, 14);
        run("bad_op", 1'b1, 2, 0);
        set_params(3'd1, 17, 2, 2, 17, 6, 10, 14);
        run("bad_17", 1'b1, 2, 0);
        set_params(3'd1, 2, 0, 2, 2, 6, 10, 14);
        run("bad_0", 1'b1, 2, 0);

        am[0] = 32'h7FFF_FFFF;
        bm[0] = 32'd2;
        load(1, 1, 1, 100, 101, 102);
        set_params(3'd1, 1, 1, 1, 1, 100, 101, 102);
        run("wrap", 1'b0, 6, 0);
        chk("wrap_c", mem[102], 32'hFFFF_FFFE);

        for (int x = 0; x < 256; x++) begin
            am[x] = 32'd1;
            bm[x] = 32'd1;
        end
        load(16, 16, 16, 0, 256, 512);
        set_params(3'd1, 16, 16, 16, 16, 0, 256, 512);
        run("mm16", 1'b0, 2 + 256 * 49, 0);
        for (int x = 0; x < 256; x += 37)
            chk("mm16_c", mem[512 + x], 32'd16);
        check_c("mm16_all", 16, 16, 16, 512);

        for (int r = 0; r < 6; r++) begin
            wa = $urandom_range(1, 4);
            ha = $urandom_range(1, 4);
            wb = $urandom_range(1, 4);
            for (int x = 0; x < 16; x++) begin
                am[x] = $urandom;
                bm[x] = (r < 3) ? 32'($urandom_range(0, 40)) - 32'd20
                                : $urandom;
            end
            gnt_rand = r[0];
            load(ha, wa, wb, 20 * r, 200 + 20 * r, 400 + 20 * r);
            set_params(3'd1, wa, ha, wb, wa, 20 * r, 200 + 20 * r,
                       400 + 20 * r);
            run("rnd", 1'b0, r[0] ? 0 : 2 + ha * wb * (3 * wa + 1), 0);
            check_c("rnd_c", ha, wa, wb, 400 + 20 * r);
        end
        gnt_rand = 1'b0;

        setup_2x2();
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (9) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(mem_req), 32'd0);
        wb_rst_i = 1'b0;
        rq = req_cnt;
        repeat (5) @(negedge wb_clk_i);
        chk("midrst_quiet", 32'(req_cnt), 32'(rq));
        setup_2x2();
        run("midrst_run", 1'b0, 30, 0);
        check_c("midrst_c", 2, 2, 2, 14);

        setup_2x2();
        run("busy_start", 1'b0, 30, 5);
        check_c("busy_start_c", 2, 2, 2, 14);

        setup_2x2();
        wb_rst_i = 1'b1;
        start    = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        start    = 1'b0;
        chk("rst_start_a", 32'(busy), 32'd0);
        @(negedge wb_clk_i);
        chk("rst_start_b", 32'(busy), 32'd0);

        chk("stable", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
